pim_matrix_loader: RTL and testbench



---
 rtl/pim_matrix_loader_pkg.sv | 14 +
 rtl/pim_zero_counter.sv | 28 ++
 rtl/pim_matrix_loader.sv | 137 +++++++++++++
 tb/tb_pim_matrix_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_matrix_loader_pkg.sv
// rtl/pim_matrix_loader_pkg.sv - shared sizes and loader state encoding for the PIM matmul path
package types;

  localparam int WIDTH       = 16;
  localparam int MATRIX_SIZE = 4;

  typedef enum logic [1:0] {
    LOAD_A      = 2'd0,
    LOAD_B      = 2'd1,
    START       = 2'd2,
    WAIT_RESULT = 2'd3
  } loader_state_t;

endpackage

// File: rtl/pim_zero_counter.sv
// rtl/pim_zero_counter.sv - saturating zero-element counter, built only with PIM_LOADER_ZERO_COUNT_EN
`ifdef PIM_LOADER_ZERO_COUNT_EN
module pim_zero_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  // clear wins over increment; stop at MAX so the count never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pim_matrix_loader.sv
// rtl/pim_matrix_loader.sv - assembles A then B from an element stream and hands them to the controller; optional PIM_LOADER_ZERO_COUNT_EN
module pim_matrix_loader #(
  parameter int WIDTH       = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [WIDTH-1:0]                                  in_data,
  input  logic                                              in_last,
  output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]          matrix_A,
  output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]          matrix_B,
  output logic                                              start,
  input  logic                                              result_ready,
  output logic                                              busy,
  output logic                                              frame_err,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE+1)-1:0]      zero_cnt_a,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE+1)-1:0]      zero_cnt_b
);

  import types::*;

  localparam int N2    = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W = $clog2(N2);
  localparam int CNT_W = $clog2(N2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N2 - 1);

  loader_state_t   state, next_state;
  logic [IDX_W-1:0] idx;
  logic hs, at_last, last_b, err, wr_a, wr_b;

  // handshake qualification; in_last must appear on exactly the final B element
  always_comb begin
    in_ready = (state == LOAD_A) || (state == LOAD_B);
    hs       = in_valid && in_ready;
    at_last  = (idx == IDX_LAST);
    last_b   = (state == LOAD_B) && at_last;
    err      = hs && (in_last != last_b);
    wr_a     = hs && !err && (state == LOAD_A);
    wr_b     = hs && !err && (state == LOAD_B);
  end

  // next-state and Moore outputs
  always_comb begin
    next_state = state;
    start      = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD_A: begin
        if (err)                 next_state = LOAD_A;
        else if (wr_a && at_last) next_state = LOAD_B;
      end
      LOAD_B: begin
        if (err)                 next_state = LOAD_A;
        else if (wr_b && at_last) next_state = START;
      end
      START: begin
        start      = 1'b1;
        busy       = 1'b1;
        next_state = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        busy = 1'b1;
        if (result_ready) next_state = LOAD_A;
      end
      default: next_state = LOAD_A;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_A;
    else      state <= next_state;
  end

  // element address within the current matrix; a framing error restarts the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (err) begin
      idx <= '0;
    end else if (wr_a || wr_b) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end else if ((state == WAIT_RESULT) && result_ready) begin
      idx <= '0;
    end
  end

  // operand storage; dropped (erroneous) elements never reach the arrays
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrix_A <= '0;
      matrix_B <= '0;
    end else begin
      if (wr_a) matrix_A[idx*WIDTH +: WIDTH] <= in_data;
      if (wr_b) matrix_B[idx*WIDTH +: WIDTH] <= in_data;
    end
  end

  // one-cycle framing error pulse, the cycle after the offending handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_err <= 1'b0;
    else      frame_err <= err;
  end

`ifdef PIM_LOADER_ZERO_COUNT_EN
  logic clr_a, clr_b, zero_in;

  // counters restart whenever their matrix is (re)entered, including error restarts
  always_comb begin
    clr_a   = (next_state == LOAD_A) && ((state != LOAD_A) || err);
    clr_b   = (state == LOAD_A) && (next_state == LOAD_B);
    zero_in = (in_data == '0);
  end

  pim_zero_counter #(.CNT_W(CNT_W), .MAX(N2)) u_zero_a (
    .clk (clk),
    .rst (rst),
    .clr (clr_a),
    .inc (wr_a && zero_in),
    .cnt (zero_cnt_a)
  );

  pim_zero_counter #(.CNT_W(CNT_W), .MAX(N2)) u_zero_b (
    .clk (clk),
    .rst (rst),
    .clr (clr_b),
    .inc (wr_b && zero_in),
    .cnt (zero_cnt_b)
  );
`else
  assign zero_cnt_a = '0;
  assign zero_cnt_b = '0;
`endif

endmodule

// File: tb/tb_pim_matrix_loader.sv
// tb/tb_pim_matrix_loader.sv - directed and randomized bench for pim_matrix_loader against a stream-level model
module tb_pim_matrix_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         in_last;
  logic [255:0] matrix_A;
  logic [255:0] matrix_B;
  logic         start;
  logic         result_ready;
  logic         busy;
  logic         frame_err;
  logic [4:0]   zero_cnt_a;
  logic [4:0]   zero_cnt_b;

  int checks = 0;
  int errors = 0;

  // reference model: position in the 32-element frame and expected contents
  logic [15:0] m_a [16];
  logic [15:0] m_b [16];
  int          m_pos;
  int          m_za, m_zb;
  logic        m_err, m_start;

  pim_matrix_loader #(.WIDTH(16), .MATRIX_SIZE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .matrix_A     (matrix_A),
    .matrix_B     (matrix_B),
    .start        (start),
    .result_ready (result_ready),
    .busy         (busy),
    .frame_err    (frame_err),
    .zero_cnt_a   (zero_cnt_a),
    .zero_cnt_b   (zero_cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_a();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = m_a[i];
    return r;
  endfunction

  function automatic logic [255:0] pack_b();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = m_b[i];
    return r;
  endfunction

  function automatic logic [255:0] exp_zc(input int v);
`ifdef PIM_LOADER_ZERO_COUNT_EN
    return 256'(v);
`else
    return 256'(v * 0);
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    m_pos = 0; m_za = 0; m_zb = 0; m_err = 0; m_start = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] d, input logic last);
    m_err   = (last != (m_pos == 31));
    m_start = 1'b0;
    if (m_err) begin
      m_pos = 0;
      m_za  = 0;
    end else begin
      if (m_pos < 16) begin
        m_a[m_pos] = d;
        if (d == 0) m_za++;
        if (m_pos == 15) m_zb = 0;
      end else begin
        m_b[m_pos-16] = d;
        if (d == 0) m_zb++;
      end
      if (m_pos == 31) begin
        m_start = 1'b1;
        m_pos   = 0;
      end else begin
        m_pos++;
      end
    end
  endfunction

  // called at a negedge; returns at the negedge following the handshake
  task automatic send(input logic [15:0] d, input logic last, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    check("in_ready_before_hs", 256'(in_ready), 256'(1));
    @(posedge clk);
    model_accept(d, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("frame_err_after_hs", 256'(frame_err), 256'(m_err));
    check("start_after_hs", 256'(start), 256'(m_start));
  endtask

  function automatic logic [15:0] rnd_elem();
    return ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
  endfunction

  // called at the START negedge: verify handoff, wait lat cycles, pulse result_ready
  task automatic finish_frame(input int lat, input bit rr_in_start);
    check("start_pulse", 256'(start), 256'(1));
    check("busy_start", 256'(busy), 256'(1));
    check("in_ready_start", 256'(in_ready), 256'(0));
    check("matrix_A_frame", matrix_A, pack_a());
    check("matrix_B_frame", matrix_B, pack_b());
    check("zero_cnt_a_start", 256'(zero_cnt_a), exp_zc(m_za));
    check("zero_cnt_b_start", 256'(zero_cnt_b), exp_zc(m_zb));
    result_ready = rr_in_start;
    @(negedge clk);
    result_ready = 1'b0;
    check("start_single_cycle", 256'(start), 256'(0));
    check("busy_wait", 256'(busy), 256'(1));
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("in_ready_wait", 256'(in_ready), 256'(0));
    end
    check("matrix_A_stable", matrix_A, pack_a());
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    m_za = 0;
    check("in_ready_rearm", 256'(in_ready), 256'(1));
    check("busy_rearm", 256'(busy), 256'(0));
    check("zero_cnt_a_rearm", 256'(zero_cnt_a), exp_zc(m_za));
    check("zero_cnt_b_held", 256'(zero_cnt_b), exp_zc(m_zb));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; result_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_in_ready", 256'(in_ready), 256'(1));
    check("reset_start", 256'(start), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_frame_err", 256'(frame_err), 256'(0));
    check("reset_matrix_A", matrix_A, pack_a());
    check("reset_matrix_B", matrix_B, pack_b());
    check("reset_zero_cnt_a", 256'(zero_cnt_a), 256'(0));
    check("reset_zero_cnt_b", 256'(zero_cnt_b), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // back-to-back A=1..16, B=identity
    for (int i = 0; i < 32; i++) begin
      logic [15:0] d;
      d = (i < 16) ? 16'(i + 1) : (((i - 16) % 5 == 0) ? 16'd1 : 16'd0);
      send(d, i == 31, 0);
    end
    check("A5_is_6", 256'(matrix_A[5*16 +: 16]), 256'(6));
    check("B0_is_1", 256'(matrix_B[0 +: 16]), 256'(1));
    check("B1_is_0", 256'(matrix_B[16 +: 16]), 256'(0));
    finish_frame(2, 1'b1);

    // same frame with every-other-cycle valid, result 10 cycles after start
    for (int i = 0; i < 32; i++) begin
      logic [15:0] d;
      d = (i < 16) ? 16'(i + 1) : (((i - 16) % 5 == 0) ? 16'd1 : 16'd0);
      send(d, i == 31, 1);
    end
    finish_frame(10, 1'b0);

    // randomized frames with random gaps
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) send(rnd_elem(), i == 31, $urandom_range(0, 2));
      finish_frame($urandom_range(1, 6), 1'b0);
    end

    // in_last on element 20: dropped, frame restarts at A[0]
    for (int i = 0; i < 19; i++) send(rnd_elem(), 1'b0, 0);
    send(16'hBEEF, 1'b1, 0);
    check("err20_in_ready", 256'(in_ready), 256'(1));
    check("err20_matrix_B", matrix_B, pack_b());
    send(16'h1234, 1'b0, 0);
    check("err20_A0_written", matrix_A, pack_a());
    check("err20_A0_value", 256'(matrix_A[0 +: 16]), 256'(16'h1234));

    // continue that frame but omit in_last on element 32
    for (int i = 1; i < 31; i++) send(rnd_elem(), 1'b0, 0);
    send(16'hCAFE, 1'b0, 0);
    check("nolast_matrix_B", matrix_B, pack_b());
    check("nolast_B15_kept", 256'(matrix_B[15*16 +: 16] == 16'hCAFE), 256'(m_b[15] == 16'hCAFE));
    check("nolast_in_ready", 256'(in_ready), 256'(1));
    check("nolast_busy", 256'(busy), 256'(0));

    // reset after 10 elements, then a fresh frame
    for (int i = 0; i < 10; i++) send(16'(i + 100), 1'b0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mid_matrix_A", matrix_A, pack_a());
    check("rst_mid_matrix_B", matrix_B, pack_b());
    check("rst_mid_in_ready", 256'(in_ready), 256'(1));
    check("rst_mid_start", 256'(start), 256'(0));
    check("rst_mid_busy", 256'(busy), 256'(0));
    check("rst_mid_frame_err", 256'(frame_err), 256'(0));
    check("rst_mid_zero_cnt", 256'({zero_cnt_a, zero_cnt_b}), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) send(rnd_elem(), i == 31, $urandom_range(0, 1));
    finish_frame(3, 1'b0);

    // sparsity: A with 6 zeros, B all zeros
    for (int i = 0; i < 32; i++) begin
      logic [15:0] d;
      d = (i >= 16) ? 16'd0 : ((i % 3 == 0) ? 16'd0 : 16'(i + 1));
      send(d, i == 31, 0);
    end
    check("zero_cnt_a_six", 256'(zero_cnt_a), exp_zc(6));
    check("zero_cnt_b_sixteen", 256'(zero_cnt_b), exp_zc(16));
    finish_frame(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
